pipeline_stage_controller: RTL

- Parametrised pipeline sequencer for an N-stage in-order core, with stage 0 = fetch and stage STAGES-1 = write-back.
- Generates per-stage start (advance) and clean (restart) strobes from downstream ready signals.
- Adds behaviour the previous fixed 4-stage controller lacked:
  - full-flush FSM with programmable clean hold and drain-complete handshake;
  - per-stage clean-pulse stretching;
  - drained indication for interrupt entry;
  - saturating back-pressure stall counter.
- Sits between the interrupt/exception unit and the stage modules.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipeline_stage_controller_stretcher.sv | 39 +++
 rtl/pipeline_stage_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stage controller.
// Stage vectors are padded with ones up to MAX_STAGES before reduction.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN
    } pipe_ctrl_state_t;

    localparam int MAX_STAGES = 32;

    function automatic logic and_range(
        input logic [MAX_STAGES-1:0] vec,
        input int                    lo
    );
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i >= lo) begin
                r = r & vec[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipeline_stage_controller_stretcher.sv
// Hold counter: a trigger reloads HOLD-1, then counts down to zero.
// Callers derive the stretched strobe as trigger | (cnt_o != 0).
module clean_pulse_stretcher #(
    parameter int HOLD = 1,
    parameter int W    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         trig_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] RELOAD = W'(HOLD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // reload on trigger, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // counter register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stage_controller.sv
// N-stage pipeline sequencer: start/clean strobes, full-flush FSM,
// per-stage clean stretching, drained flag and saturating stall count.
module pipeline_stage_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter int CLEAN_HOLD = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop_new_i,
    input  logic              flush_all_i,
    input  logic [STAGES-1:0] clean_req_i,
    input  logic [STAGES-1:0] ready_i,
    output logic [STAGES-2:0] start_o,
    output logic [STAGES-1:0] clean_o,
    output logic              busy_o,
    output logic              flush_done_o,
    output logic              drained_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              stall_cnt_clr_i
);

    localparam int HOLD_W = $clog2(CLEAN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam pipe_ctrl_state_t FLUSH_TGT =
        (CLEAN_HOLD > 1) ? FLUSH : DRAIN;

    pipe_ctrl_state_t state_q;
    pipe_ctrl_state_t state_d;

    logic                  done_q;
    logic                  done_d;
    logic [CNT_W-1:0]      stall_q;
    logic [CNT_W-1:0]      stall_d;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     str_cnt [STAGES];
    logic [STAGES-1:0]     str_on;
    logic [MAX_STAGES-1:0] rdy_ext;
    logic [STAGES-2:0]     start_raw;
    logic                  rdy_down;
    logic                  rdy_all;
    logic                  is_idle;
    logic                  flush_term;
    logic                  stall_inc;

    assign rdy_ext    = {{(MAX_STAGES - STAGES){1'b1}}, ready_i};
    assign rdy_down   = and_range(rdy_ext, 1);
    assign rdy_all    = and_range(rdy_ext, 0);
    assign is_idle    = (state_q == IDLE);
    assign flush_term = flush_all_i | (state_q == FLUSH);

    clean_pulse_stretcher #(
        .HOLD (CLEAN_HOLD),
        .W    (HOLD_W)
    ) u_flush_hold (
        .clk    (clk),
        .rst    (rst),
        .trig_i (flush_all_i),
        .cnt_o  (hold_cnt)
    );

    for (genvar g = 0; g < STAGES; g++) begin : g_str
        clean_pulse_stretcher #(
            .HOLD (CLEAN_HOLD),
            .W    (HOLD_W)
        ) u_str (
            .clk    (clk),
            .rst    (rst),
            .trig_i (clean_req_i[g]),
            .cnt_o  (str_cnt[g])
        );
        assign str_on[g] = clean_req_i[g] | (str_cnt[g] != '0);
    end

    // start strobes: a stage advances when everything downstream is ready
    always_comb begin
        start_raw = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            start_raw[i] = and_range(rdy_ext, i + 1);
        end
        start_raw[0] = start_raw[0] & ~stop_new_i
                     & is_idle & ~flush_all_i;
    end

    // flush FSM next state and completion pulse
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_all_i) begin
                    state_d = FLUSH_TGT;
                end
            end
            FLUSH: begin
                if (!flush_all_i && hold_cnt == HOLD_ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_all_i) begin
                    state_d = FLUSH_TGT;
                end else if (rdy_down) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // stall counter: clear wins, saturate at all ones
    always_comb begin
        stall_inc = is_idle & ~stop_new_i & ~start_raw[0];
        stall_d   = stall_q;
        if (stall_cnt_clr_i) begin
            stall_d = '0;
        end else if (stall_inc && stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // state registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    // outputs are forced to their safe values while reset is held
    always_comb begin
        start_o      = '0;
        clean_o      = '1;
        busy_o       = 1'b0;
        drained_o    = 1'b0;
        flush_done_o = 1'b0;
        stall_cnt_o  = '0;
        if (rst) begin
            start_o      = start_raw;
            clean_o      = str_on
                         | {1'b0, {(STAGES - 1){flush_term}}};
            busy_o       = ~is_idle;
            drained_o    = stop_new_i & is_idle & rdy_all;
            flush_done_o = done_q;
            stall_cnt_o  = stall_q;
        end
    end

endmodule
